// File: rtl/module_multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle RV32I control path.
package pkg_multicycle;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format selected purely from the opcode; unknown opcodes fall to I.
  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_SW:   imm_sel = IMM_S;
      OP_BEQ:  imm_sel = IMM_B;
      OP_JAL:  imm_sel = IMM_J;
      default: imm_sel = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/module_multicycle_controller_alu_decoder.sv
// Combinational aluop/funct to ALU control mapping.
module module_alu_decoder
  import pkg_multicycle::*;
(
  input  logic [1:0] aluop_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7b5_i,
  output logic [2:0] alucontrol_o
);

  // Select the ALU operation from the FSM's aluop and the instruction fields.
  always_comb begin
    alucontrol_o = ALU_ADD;
    case (aluop_i)
      ALUOP_ADD: alucontrol_o = ALU_ADD;
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000:  alucontrol_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol_o = ALU_SLT;
          3'b110:  alucontrol_o = ALU_OR;
          3'b111:  alucontrol_o = ALU_AND;
          default: alucontrol_o = ALU_ADD;
        endcase
      end
      default: alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/module_multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequencing, datapath
// selects, memory handshake stalls and retired-instruction counter.
module module_multicycle_controller
  import pkg_multicycle::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [6:0]  op_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7b5_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        pcwrite_o,
  output logic        adrsrc_o,
  output logic        memwrite_o,
  output logic        irwrite_o,
  output logic        regwrite_o,
  output logic [1:0]  resultsrc_o,
  output logic [1:0]  alusrca_o,
  output logic [1:0]  alusrcb_o,
  output logic [1:0]  immsrc_o,
  output logic [2:0]  alucontrol_o,
  output logic        illegal_o,
  output logic [3:0]  state_o,
  output logic [31:0] instret_o
);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_instret;

  logic        w_pcupdate;
  logic        w_branch;
  logic        w_irwrite;
  logic        w_memwrite;
  logic        w_regwrite;
  logic        w_illegal;
  logic        w_retire;
  logic [1:0]  w_aluop;

  // State register; reset parks the FSM in FETCH.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Next-state and Moore output decode.
  always_comb begin
    w_next      = r_state;
    w_pcupdate  = 1'b0;
    w_branch    = 1'b0;
    w_irwrite   = 1'b0;
    w_memwrite  = 1'b0;
    w_regwrite  = 1'b0;
    w_illegal   = 1'b0;
    w_retire    = 1'b0;
    w_aluop     = ALUOP_ADD;
    adrsrc_o    = 1'b0;
    resultsrc_o = RES_ALUOUT;
    alusrca_o   = SRCA_PC;
    alusrcb_o   = SRCB_RS2;
    case (r_state)
      S_FETCH: begin
        alusrcb_o   = SRCB_FOUR;
        resultsrc_o = RES_ALURESULT;
        w_irwrite   = mem_ready_i;
        w_pcupdate  = mem_ready_i;
        if (mem_ready_i) w_next = S_DECODE;
      end
      S_DECODE: begin
        alusrca_o = SRCA_OLDPC;
        alusrcb_o = SRCB_IMM;
        case (op_i)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECUTER;
          OP_I:         w_next = S_EXECUTEI;
          OP_JAL:       w_next = S_JAL;
          OP_BEQ:       w_next = S_BEQ;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca_o = SRCA_RS1;
        alusrcb_o = SRCB_IMM;
        w_next    = (op_i == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adrsrc_o = 1'b1;
        if (mem_ready_i) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc_o = RES_DATA;
        w_regwrite  = 1'b1;
        w_next      = S_FETCH;
        w_retire    = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc_o   = 1'b1;
        w_memwrite = 1'b1;
        if (mem_ready_i) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end
      end
      S_EXECUTER: begin
        alusrca_o = SRCA_RS1;
        alusrcb_o = SRCB_RS2;
        w_aluop   = ALUOP_FUNCT;
        w_next    = S_ALUWB;
      end
      S_EXECUTEI: begin
        alusrca_o = SRCA_RS1;
        alusrcb_o = SRCB_IMM;
        w_aluop   = ALUOP_FUNCT;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
        w_retire   = 1'b1;
      end
      S_JAL: begin
        alusrca_o  = SRCA_OLDPC;
        alusrcb_o  = SRCB_FOUR;
        w_pcupdate = 1'b1;
        w_next     = S_ALUWB;
      end
      S_BEQ: begin
        alusrca_o = SRCA_RS1;
        alusrcb_o = SRCB_RS2;
        w_aluop   = ALUOP_SUB;
        w_branch  = 1'b1;
        w_next    = S_FETCH;
        w_retire  = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Retired-instruction counter; advances on the edge that completes an instruction.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)        r_instret <= '0;
    else if (w_retire) r_instret <= r_instret + 32'd1;
  end

  module_alu_decoder u_alu_decoder (
    .aluop_i      (w_aluop),
    .funct3_i     (funct3_i),
    .op5_i        (op_i[5]),
    .funct7b5_i   (funct7b5_i),
    .alucontrol_o (alucontrol_o)
  );

  // Write strobes are qualified by reset so FETCH's ready-driven enables stay low in reset.
  assign pcwrite_o  = rst_i & (w_pcupdate | (w_branch & zero_i));
  assign irwrite_o  = rst_i & w_irwrite;
  assign memwrite_o = rst_i & w_memwrite;
  assign regwrite_o = rst_i & w_regwrite;
  assign illegal_o  = rst_i & w_illegal;
  assign immsrc_o   = imm_sel(op_i);
  assign state_o    = r_state;
  assign instret_o  = r_instret;

endmodule

// File: tb/tb_module_multicycle_controller.sv
module tb_module_multicycle_controller;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [6:0]  op_i;
  logic [2:0]  funct3_i;
  logic        funct7b5_i;
  logic        zero_i;
  logic        mem_ready_i;
  logic        pcwrite_o, adrsrc_o, memwrite_o, irwrite_o, regwrite_o, illegal_o;
  logic [1:0]  resultsrc_o, alusrca_o, alusrcb_o, immsrc_o;
  logic [2:0]  alucontrol_o;
  logic [3:0]  state_o;
  logic [31:0] instret_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_instret;

  // results of the last run_instr
  int          cycles;
  bit          done;
  logic [3:0]  st_tr  [0:39];
  logic [2:0]  alu_tr [0:39];
  logic [1:0]  rs_tr  [0:39];
  logic [15:0] reg_mask;
  logic [15:0] pcw_mask;
  int          n_ir, n_mw, n_ill, mw_adr_bad, mw_run, mw_run_max;

  always #5 clk_i = ~clk_i;

  module_multicycle_controller dut (
    .clk_i(clk_i), .rst_i(rst_i), .op_i(op_i), .funct3_i(funct3_i),
    .funct7b5_i(funct7b5_i), .zero_i(zero_i), .mem_ready_i(mem_ready_i),
    .pcwrite_o(pcwrite_o), .adrsrc_o(adrsrc_o), .memwrite_o(memwrite_o),
    .irwrite_o(irwrite_o), .regwrite_o(regwrite_o), .resultsrc_o(resultsrc_o),
    .alusrca_o(alusrca_o), .alusrcb_o(alusrcb_o), .immsrc_o(immsrc_o),
    .alucontrol_o(alucontrol_o), .illegal_o(illegal_o), .state_o(state_o),
    .instret_o(instret_o)
  );

  // Drives one instruction from FETCH back to FETCH and records what the
  // outputs did; called on a negedge with the DUT in FETCH.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic z, input int fetch_waits, input int mem_waits);
    int fw = fetch_waits;
    int mw = mem_waits;
    bit left = 0;
    op_i = op; funct3_i = f3; funct7b5_i = f7; zero_i = z;
    done = 0; cycles = 0; reg_mask = '0; pcw_mask = '0;
    n_ir = 0; n_mw = 0; n_ill = 0; mw_adr_bad = 0; mw_run = 0; mw_run_max = 0;
    for (int c = 0; c < 40; c++) begin
      if (left && state_o == 4'd0) begin
        done = 1; cycles = c; break;
      end
      if (state_o == 4'd0) begin
        mem_ready_i = (fw == 0);
        if (fw > 0) fw--;
      end else if (state_o == 4'd3 || state_o == 4'd5) begin
        mem_ready_i = (mw == 0);
        if (mw > 0) mw--;
      end else begin
        mem_ready_i = 1'b0;
      end
      #1;
      st_tr[c] = state_o; alu_tr[c] = alucontrol_o; rs_tr[c] = resultsrc_o;
      if (regwrite_o) reg_mask[state_o] = 1'b1;
      if (pcwrite_o)  pcw_mask[state_o] = 1'b1;
      if (irwrite_o)  n_ir++;
      if (illegal_o)  n_ill++;
      if (memwrite_o) begin
        n_mw++; mw_run++;
        if (mw_run > mw_run_max) mw_run_max = mw_run;
        if (adrsrc_o !== 1'b1) mw_adr_bad++;
      end else mw_run = 0;
      if (state_o != 4'd0) left = 1;
      @(posedge clk_i); @(negedge clk_i);
    end
    mem_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; mem_ready_i = 1'b1; op_i = 7'd0; funct3_i = 3'd0;
    funct7b5_i = 1'b0; zero_i = 1'b0;
    #12;
    checks++;
    if (state_o !== 4'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    checks++;
    if (instret_o !== 32'd0) begin failures++; $display("FAIL reset_instret got=%0d exp=0", instret_o); end
    checks++;
    if ({pcwrite_o, irwrite_o, memwrite_o, regwrite_o, illegal_o} !== 5'b0) begin
      failures++; $display("FAIL reset_strobes got=%b exp=00000",
                           {pcwrite_o, irwrite_o, memwrite_o, regwrite_o, illegal_o});
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    checks++;
    if ({alusrcb_o, resultsrc_o, irwrite_o, pcwrite_o} !== 6'b10_10_1_1) begin
      failures++; $display("FAIL fetch_outputs got=%b exp=101011",
                           {alusrcb_o, resultsrc_o, irwrite_o, pcwrite_o});
    end
    exp_instret = 32'd0;
  endtask

  task automatic test_r_type();
    run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0);
    checks++;
    if (!done || cycles != 4) begin failures++; $display("FAIL r_add_latency got=%0d exp=4", cycles); end
    checks++;
    if ({st_tr[0], st_tr[1], st_tr[2], st_tr[3]} !== {4'd0, 4'd1, 4'd6, 4'd7}) begin
      failures++; $display("FAIL r_add_states got=%0d,%0d,%0d,%0d exp=0,1,6,7",
                           st_tr[0], st_tr[1], st_tr[2], st_tr[3]);
    end
    checks++;
    if (alu_tr[2] !== 3'b000) begin failures++; $display("FAIL r_add_alu got=%b exp=000", alu_tr[2]); end
    checks++;
    if (reg_mask !== 16'h0080) begin failures++; $display("FAIL r_add_regwrite got=%h exp=0080", reg_mask); end
    exp_instret++;
    checks++;
    if (instret_o !== exp_instret) begin failures++; $display("FAIL r_add_instret got=%0d exp=%0d", instret_o, exp_instret); end

    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0);
    exp_instret++;
    checks++;
    if (alu_tr[2] !== 3'b001) begin failures++; $display("FAIL r_sub_alu got=%b exp=001", alu_tr[2]); end
    run_instr(7'b0110011, 3'b111, 1'b0, 1'b0, 0, 0);
    exp_instret++;
    checks++;
    if (alu_tr[2] !== 3'b010) begin failures++; $display("FAIL r_and_alu got=%b exp=010", alu_tr[2]); end
  endtask

  task automatic test_i_type();
    run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0);
    exp_instret++;
    checks++;
    if (st_tr[2] !== 4'd8 || alu_tr[2] !== 3'b000) begin
      failures++; $display("FAIL i_addi_alu got=st%0d/%b exp=st8/000", st_tr[2], alu_tr[2]);
    end
    run_instr(7'b0010011, 3'b010, 1'b0, 1'b0, 0, 0);
    exp_instret++;
    checks++;
    if (alu_tr[2] !== 3'b101) begin failures++; $display("FAIL i_slti_alu got=%b exp=101", alu_tr[2]); end
    run_instr(7'b0010011, 3'b110, 1'b0, 1'b0, 0, 0);
    exp_instret++;
    checks++;
    if (alu_tr[2] !== 3'b011 || cycles != 4) begin
      failures++; $display("FAIL i_ori got=%b/%0d exp=011/4", alu_tr[2], cycles);
    end
    checks++;
    if (instret_o !== exp_instret) begin failures++; $display("FAIL i_instret got=%0d exp=%0d", instret_o, exp_instret); end
  endtask

  task automatic test_lw_waits();
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 2, 3);
    exp_instret++;
    checks++;
    if (!done || cycles != 10) begin failures++; $display("FAIL lw_latency got=%0d exp=10", cycles); end
    checks++;
    if (n_ir != 1) begin failures++; $display("FAIL lw_irwrite_pulses got=%0d exp=1", n_ir); end
    checks++;
    if (reg_mask !== 16'h0010) begin failures++; $display("FAIL lw_regwrite got=%h exp=0010", reg_mask); end
    checks++;
    if (rs_tr[9] !== 2'b01 || st_tr[9] !== 4'd4) begin
      failures++; $display("FAIL lw_memwb got=st%0d/rs%b exp=st4/rs01", st_tr[9], rs_tr[9]);
    end
    checks++;
    if (immsrc_o !== 2'b00) begin failures++; $display("FAIL lw_immsrc got=%b exp=00", immsrc_o); end
    checks++;
    if (instret_o !== exp_instret) begin failures++; $display("FAIL lw_instret got=%0d exp=%0d", instret_o, exp_instret); end
  endtask

  task automatic test_sw_wait();
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 1);
    exp_instret++;
    checks++;
    if (!done || cycles != 5) begin failures++; $display("FAIL sw_latency got=%0d exp=5", cycles); end
    checks++;
    if (n_mw != 2 || mw_run_max != 2 || mw_adr_bad != 0) begin
      failures++; $display("FAIL sw_memwrite got=n%0d/run%0d/adrbad%0d exp=n2/run2/adrbad0", n_mw, mw_run_max, mw_adr_bad);
    end
    checks++;
    if (reg_mask !== 16'h0000) begin failures++; $display("FAIL sw_regwrite got=%h exp=0000", reg_mask); end
    checks++;
    if (immsrc_o !== 2'b01) begin failures++; $display("FAIL sw_immsrc got=%b exp=01", immsrc_o); end
    checks++;
    if (instret_o !== exp_instret) begin failures++; $display("FAIL sw_instret got=%0d exp=%0d", instret_o, exp_instret); end
  endtask

  task automatic test_branch_jump();
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0);
    exp_instret++;
    checks++;
    if (!done || cycles != 3 || pcw_mask !== 16'h0401) begin
      failures++; $display("FAIL beq_taken got=%0d/%h exp=3/0401", cycles, pcw_mask);
    end
    checks++;
    if (alu_tr[2] !== 3'b001) begin failures++; $display("FAIL beq_alu got=%b exp=001", alu_tr[2]); end
    checks++;
    if (immsrc_o !== 2'b10) begin failures++; $display("FAIL beq_immsrc got=%b exp=10", immsrc_o); end
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0);
    exp_instret++;
    checks++;
    if (!done || cycles != 3 || pcw_mask !== 16'h0001) begin
      failures++; $display("FAIL beq_not_taken got=%0d/%h exp=3/0001", cycles, pcw_mask);
    end
    run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0);
    exp_instret++;
    checks++;
    if (!done || cycles != 4 || st_tr[2] !== 4'd9 || pcw_mask !== 16'h0201 || reg_mask !== 16'h0080) begin
      failures++; $display("FAIL jal got=%0d/st%0d/pcw%h/reg%h exp=4/st9/pcw0201/reg0080",
                           cycles, st_tr[2], pcw_mask, reg_mask);
    end
    checks++;
    if (immsrc_o !== 2'b11) begin failures++; $display("FAIL jal_immsrc got=%b exp=11", immsrc_o); end
    checks++;
    if (instret_o !== exp_instret) begin failures++; $display("FAIL bj_instret got=%0d exp=%0d", instret_o, exp_instret); end
  endtask

  task automatic test_illegal();
    run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0);
    checks++;
    if (!done || cycles != 2 || n_ill != 1 || st_tr[1] !== 4'd1) begin
      failures++; $display("FAIL illegal got=%0d/%0d/st%0d exp=2/1/st1", cycles, n_ill, st_tr[1]);
    end
    checks++;
    if (instret_o !== exp_instret) begin failures++; $display("FAIL illegal_instret got=%0d exp=%0d", instret_o, exp_instret); end
  endtask

  task automatic test_reset_mid_memwrite();
    int k;
    op_i = 7'b0100011; funct3_i = 3'b010;
    k = 0;
    while (state_o !== 4'd5 && k < 10) begin
      mem_ready_i = (state_o == 4'd0);
      @(posedge clk_i); @(negedge clk_i);
      k++;
    end
    mem_ready_i = 1'b0;
    #1;
    checks++;
    if (state_o !== 4'd5 || memwrite_o !== 1'b1) begin
      failures++; $display("FAIL mid_sw_reach got=st%0d/mw%b exp=st5/mw1", state_o, memwrite_o);
    end
    checks++;
    if (instret_o === 32'd0) begin failures++; $display("FAIL mid_sw_precount got=0 exp=nonzero"); end
    mem_ready_i = 1'b1;
    rst_i = 1'b0;
    #1;
    checks++;
    if (memwrite_o !== 1'b0 || state_o !== 4'd0 || instret_o !== 32'd0) begin
      failures++; $display("FAIL mid_sw_reset got=mw%b/st%0d/cnt%0d exp=mw0/st0/cnt0", memwrite_o, state_o, instret_o);
    end
    checks++;
    if (pcwrite_o !== 1'b0 || irwrite_o !== 1'b0) begin
      failures++; $display("FAIL mid_sw_reset_strobes got=%b%b exp=00", pcwrite_o, irwrite_o);
    end
    @(posedge clk_i); @(negedge clk_i);
    rst_i = 1'b1;
    exp_instret = 32'd0;
    run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0);
    exp_instret++;
    checks++;
    if (!done || cycles != 4 || instret_o !== exp_instret) begin
      failures++; $display("FAIL post_reset_r got=%0d/%0d exp=4/%0d", cycles, instret_o, exp_instret);
    end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_i_type();
    test_lw_waits();
    test_sw_wait();
    test_branch_jump();
    test_illegal();
    test_reset_mid_memwrite();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
